// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//   Round-robin front end that shares one restoring divider among N
//   requesters. The winner's operands are latched, the divider's start/ready
//   handshake is sequenced, and the result is returned with a one-hot done
//   pulse. A zero divisor short-circuits without starting the divider.
//
// Optional feature (compile-time macro): DIV_ARB_TIMEOUT_EN
//   Defined   : WAIT runs a watchdog; after TIMEOUT cycles without div_ready
//               the operation completes with quotient=0, remainder=0,
//               timeout_err=1.
//   Undefined : WAIT waits indefinitely; timeout_err is tied 0.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   req[N]              request levels; operands held stable while high
//   req_sign[N]         signed(1)/unsigned(0) select per requester
//   req_dividend/divisor packed operands, requester i at [i*WIDTH +: WIDTH]
//   done[N]             one-hot one-cycle completion pulse
//   quotient/remainder  registered result, held until the next done
//   div_by_zero         result qualifier: divisor was zero
//   timeout_err         result qualifier: divider watchdog expired
//   busy                high whenever not IDLE
//   div_start/sign/dividend/divisor   to divider
//   div_quotient/remainder/ready      from divider
// -----------------------------------------------------------------------------
module div_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 36,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       req_sign,
  input  logic [N*WIDTH-1:0] req_dividend,
  input  logic [N*WIDTH-1:0] req_divisor,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               timeout_err,
  output logic               busy,
  output logic               div_start,
  output logic               div_sign,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  input  logic               div_ready
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_idx;
  logic             r_sign;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic             r_wait_armed;

  logic             w_found;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_cand;
  logic             w_ready_ok;
  logic             w_timeout;
  logic             w_busy;
  logic             w_start;
  logic [N-1:0]     w_done;

  logic [WIDTH-1:0] w_dvd_arr [N];
  logic [WIDTH-1:0] w_dvs_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_dvd_arr[g] = req_dividend[g*WIDTH +: WIDTH];
    assign w_dvs_arr[g] = req_divisor[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(r_rr_ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // r_wait_armed is low in the first WAIT cycle, so a ready pulse left over
  // from an aborted operation cannot complete the new one.
  assign w_ready_ok = div_ready & r_wait_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b1;
    w_start = 1'b0;
    w_done  = '0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_found) begin
          w_next = (w_dvs_arr[w_win] == '0) ? S_ZERO : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (w_ready_ok || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_ZERO: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done[r_idx] = 1'b1;
        w_next        = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr      <= IW'(N - 1);
      r_idx         <= '0;
      r_sign        <= 1'b0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_wait_armed  <= 1'b0;
    end else begin
      r_wait_armed <= (r_state == S_WAIT);
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx      <= w_win;
            r_rr_ptr   <= w_win;
            r_sign     <= req_sign[w_win];
            r_dividend <= w_dvd_arr[w_win];
            r_divisor  <= w_dvs_arr[w_win];
          end
        end
        S_WAIT: begin
          if (w_ready_ok) begin
            r_quotient    <= div_quotient;
            r_remainder   <= div_remainder;
            r_div_by_zero <= 1'b0;
          end else if (w_timeout) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
          end
        end
        S_ZERO: begin
          r_quotient    <= '1;
          r_remainder   <= r_dividend;
          r_div_by_zero <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_tmo_cnt;
  logic          r_timeout_err;

  // Counter reads 0 in the first WAIT cycle; the TIMEOUT-th WAIT cycle exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
      if (r_state == S_WAIT && w_ready_ok) begin
        r_timeout_err <= 1'b0;
      end else if (r_state == S_WAIT && w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (r_state == S_ZERO) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign w_timeout   = (r_tmo_cnt == CW'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign done         = w_done;
  assign busy         = w_busy;
  assign div_start    = w_start;
  assign div_sign     = r_sign;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign quotient     = r_quotient;
  assign remainder    = r_remainder;
  assign div_by_zero  = r_div_by_zero;

endmodule

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps
module tb_div_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 36;
  localparam int unsigned TMO = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_sign = '0;
  logic [N*W-1:0]   req_dividend = '0;
  logic [N*W-1:0]   req_divisor = '0;
  logic [N-1:0]     done;
  logic [W-1:0]     quotient, remainder;
  logic             div_by_zero, timeout_err, busy, div_start, div_sign;
  logic [W-1:0]     div_dividend, div_divisor;
  logic [W-1:0]     div_quotient = '0;
  logic [W-1:0]     div_remainder = '0;
  logic             div_ready = 1'b0;

  div_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_sign(req_sign),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .timeout_err(timeout_err), .busy(busy),
    .div_start(div_start), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference division: truncating integer division on the operand values.
  function automatic logic [W-1:0] ref_div(input bit s, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input bit want_rem);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == '0) return '1;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return W'(want_rem ? sa % sb : sa / sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return W'(want_rem ? ua % ub : ua / ub);
  endfunction

  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 1; k <= int'(N); k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // Divider stand-in: start on a rising div_start, ready after stub_lat
  // cycles, optional bogus ready in the cycle right after start.
  int         starts = 0;
  int         stub_cnt = 0;
  int         stub_lat = 2;
  int         force_lat = 0;
  bit         stub_busy = 1'b0;
  bit         stub_stale = 1'b0;
  bit         stub_mute = 1'b0;
  bit         prev_start = 1'b0;
  bit         stub_s = 1'b0;
  logic [W-1:0] stub_a = '0, stub_b = '0;

  always @(negedge clk) begin
    div_ready     = 1'b0;
    div_quotient  = W'({$urandom, $urandom});
    div_remainder = W'({$urandom, $urandom});
    if (div_start && !prev_start) begin
      starts++;
      stub_busy  = !stub_mute;
      stub_cnt   = 0;
      stub_lat   = (force_lat != 0) ? force_lat : int'($urandom_range(2, W + 2));
      stub_stale = 1'($urandom_range(0, 1));
      stub_s     = div_sign;
      stub_a     = div_dividend;
      stub_b     = div_divisor;
    end else if (stub_busy) begin
      stub_cnt++;
      if (stub_cnt == stub_lat) begin
        div_ready     = 1'b1;
        div_quotient  = ref_div(stub_s, stub_a, stub_b, 1'b0);
        div_remainder = ref_div(stub_s, stub_a, stub_b, 1'b1);
        stub_busy     = 1'b0;
      end else if (stub_cnt == 1 && stub_stale) begin
        div_ready = 1'b1;
      end
    end
    prev_start = div_start;
  end

  logic [W-1:0] op_dvd [N];
  logic [W-1:0] op_dvs [N];
  logic [N-1:0] op_sgn = '0;
  int           model_rr = N - 1;

  task automatic drive_ops();
    for (int i = 0; i < int'(N); i++) begin
      req_dividend[i*W +: W] = op_dvd[i];
      req_divisor[i*W +: W]  = op_dvs[i];
    end
    req_sign = op_sgn;
  endtask

  // Raise all requesters in mask at an IDLE negedge; each drops on its done.
  task automatic serve_round(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int           w, n, st0, exp_n;
    bit           z;
    logic [W-1:0] eq, er;
    logic         edz, eto;
    pend = mask;
    drive_ops();
    req = mask;
    while (pend != '0) begin
      w   = rr_pick(model_rr, pend);
      z   = (op_dvs[w] == '0);
      st0 = starts;
      n   = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done == '0 && n < 300);
      if (done == '0) begin
        check("done_seen", 64'(0), 64'(1));
        req = '0;
        return;
      end
      if (z) begin
        exp_n = 2; eq = '1; er = op_dvd[w]; edz = 1'b1; eto = 1'b0;
      end else if (stub_mute) begin
        exp_n = TMO + 2; eq = '0; er = '0; edz = 1'b0; eto = 1'b1;
      end else begin
        exp_n = stub_lat + 2;
        eq  = ref_div(op_sgn[w], op_dvd[w], op_dvs[w], 1'b0);
        er  = ref_div(op_sgn[w], op_dvd[w], op_dvs[w], 1'b1);
        edz = 1'b0; eto = 1'b0;
      end
      check("done_onehot", 64'(done), 64'(1) << w);
      check("latency", 64'(n), 64'(exp_n));
      check("start_pulses", 64'(starts - st0), z ? 64'(0) : 64'(1));
      check("quotient", 64'(quotient), 64'(eq));
      check("remainder", 64'(remainder), 64'(er));
      check("div_by_zero", 64'(div_by_zero), 64'(edz));
      check("timeout_err", 64'(timeout_err), 64'(eto));
      check("latched_dividend", 64'(div_dividend), 64'(op_dvd[w]));
      check("latched_sign", 64'(div_sign), 64'(op_sgn[w]));
      model_rr = w;
      pend[w]  = 1'b0;
      req[w]   = 1'b0;
      @(negedge clk);
      check("busy_after_done", 64'(busy), 64'(0));
      check("done_one_cycle", 64'(done), 64'(0));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int i = 0; i < int'(N); i++) begin
      op_dvd[i] = '0;
      op_dvs[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_start", 64'(div_start), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_tmo", 64'(timeout_err), 64'(0));
    check("rst_div_ops", 64'({div_sign, div_dividend, div_divisor} != '0), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Round-robin from reset: 1011 served 0, 1, 3; then 0011 serves 0 first.
    op_dvd[0] = 36'd1000; op_dvs[0] = 36'd3;
    op_dvd[1] = 36'd2000; op_dvs[1] = 36'd7;
    op_dvd[3] = 36'd3000; op_dvs[3] = 36'd11;
    serve_round(4'b1011);
    check("rr_last_q", 64'(quotient), 64'(272));
    check("rr_last_r", 64'(remainder), 64'(8));
    serve_round(4'b0011);

    // Unsigned 100/7.
    op_dvd[0] = 36'd100; op_dvs[0] = 36'd7; op_sgn = 4'b0000;
    serve_round(4'b0001);
    check("uns_q", 64'(quotient), 64'(14));
    check("uns_r", 64'(remainder), 64'(2));

    // Signed -100/7.
    op_dvd[1] = 36'hFFFFFFF9C; op_dvs[1] = 36'd7; op_sgn = 4'b0010;
    serve_round(4'b0010);
    check("sgn_q", 64'(quotient), 64'(36'hFFFFFFFF2));
    check("sgn_r", 64'(remainder), 64'(36'hFFFFFFFFE));

    // Zero divisor.
    op_dvd[2] = 36'd55; op_dvs[2] = '0; op_sgn = '0;
    serve_round(4'b0100);
    check("zero_q", 64'(quotient), 64'(36'hFFFFFFFFF));
    check("zero_r", 64'(remainder), 64'(55));

    // Reset while waiting on the divider; its late ready must be ignored.
    force_lat = 30;
    op_dvd[0] = 36'd1000; op_dvs[0] = 36'd3;
    drive_ops();
    req = 4'b0001;
    repeat (10) @(negedge clk);
    check("busy_in_wait", 64'(busy), 64'(1));
    reset = 1'b1;
    req   = '0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_start", 64'(div_start), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done != '0 || busy) seen++;
    end
    check("stale_ready_ignored", 64'(seen), 64'(0));
    force_lat = 0;
    model_rr  = N - 1;
    op_dvd[0] = 36'd200; op_dvs[0] = 36'd9;
    serve_round(4'b0001);
    check("post_rst_q", 64'(quotient), 64'(22));
    check("post_rst_r", 64'(remainder), 64'(2));

`ifdef DIV_ARB_TIMEOUT_EN
    stub_mute = 1'b1;
    op_dvd[2] = 36'd77; op_dvs[2] = 36'd5;
    serve_round(4'b0100);
    stub_mute = 1'b0;
    op_dvd[1] = 36'd50; op_dvs[1] = 36'd5;
    op_dvd[3] = 36'd60; op_dvs[3] = 36'd6;
    serve_round(4'b1010);
`endif

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < int'(N); i++) begin
        op_sgn[i] = 1'($urandom_range(0, 1));
        op_dvd[i] = W'({$urandom, $urandom});
        case ($urandom_range(0, 3))
          0:       op_dvs[i] = '0;
          1:       op_dvs[i] = W'($urandom_range(1, 20));
          default: op_dvs[i] = W'({$urandom, $urandom});
        endcase
      end
      serve_round(m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
